// File: rtl/coef_bank_if.sv
// rtl/coef_bank_if.sv - load, stream-launch and coefficient-stream signals of coef_bank
interface coef_bank_if #(
    parameter int DW    = 16,
    parameter int AW    = 6,
    parameter int NBANK = 2
);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic          wr_en;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;

    logic          start;
    logic [BW-1:0] rd_bank;
    logic [AW:0]   rd_len;
    logic          rd_rev;
    logic          cfg_err;
    logic          busy;

    logic [DW-1:0] coef_data;
    logic          coef_valid;
    logic          coef_ready;
    logic          coef_last;
    logic          done;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, start, rd_bank, rd_len, rd_rev, coef_ready,
        input  wr_err, cfg_err, busy, coef_data, coef_valid, coef_last, done
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, start, rd_bank, rd_len, rd_rev, coef_ready,
        output wr_err, cfg_err, busy, coef_data, coef_valid, coef_last, done
    );
endinterface

// File: rtl/coef_bank.sv
// rtl/coef_bank.sv - banked coefficient store with a backpressured streaming read port
module coef_bank #(
    parameter int DW    = 16,
    parameter int AW    = 6,
    parameter int NBANK = 2
) (
    input logic       clk,
    input logic       rst,
    coef_bank_if.slave bus
);
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bank_q, bank_d;
    logic [AW:0]   len_q, len_d;
    logic          rev_q, rev_d;
    logic [AW:0]   issued_q, issued_d;
    logic [DW-1:0] coef_data_q, coef_data_d;
    logic          coef_valid_q, coef_valid_d;
    logic          coef_last_q, coef_last_d;
    logic          wr_err_q, wr_err_d;
    logic          cfg_err_q, cfg_err_d;

    logic [DW-1:0] mem [NBANK][DEPTH];

    logic          busy, done;
    logic          start_ok, handshake, load, wr_hit, wr_fire;
    logic [AW:0]   rd_idx;
    logic [AW-1:0] rd_addr;

    // Decode of the launch request, the output handshake and the load-port collision
    always_comb begin
        start_ok  = bus.start && (bus.rd_len != '0) && (bus.rd_len <= DEPTH_L)
                    && (int'(bus.rd_bank) < NBANK);
        handshake = coef_valid_q && bus.coef_ready;
        load      = (state_q == S_STREAM) && (issued_q != len_q)
                    && (!coef_valid_q || bus.coef_ready);
        rd_idx    = rev_q ? (len_q - 1'b1 - issued_q) : issued_q;
        rd_addr   = rd_idx[AW-1:0];
        wr_hit    = bus.wr_en && busy && (bus.wr_bank == bank_q);
        wr_fire   = bus.wr_en && !wr_hit && (int'(bus.wr_bank) < NBANK);
    end

    // Coefficient storage: synchronous write, never cleared by reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: PRIME spends one cycle so the first word appears two edges after start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_PRIME;
            S_PRIME:  state_d = S_STREAM;
            S_STREAM: if (handshake && coef_last_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy spans PRIME through DONE, done marks the single DONE cycle
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next values: latch the launch config, refill the output register when it frees up
    always_comb begin
        bank_d       = bank_q;
        len_d        = len_q;
        rev_d        = rev_q;
        issued_d     = issued_q;
        coef_data_d  = coef_data_q;
        coef_valid_d = coef_valid_q;
        coef_last_d  = coef_last_q;
        wr_err_d     = wr_hit;
        cfg_err_d    = (state_q == S_IDLE) && bus.start && !start_ok;
        if (state_q == S_IDLE && start_ok) begin
            bank_d   = bus.rd_bank;
            len_d    = bus.rd_len;
            rev_d    = bus.rd_rev;
            issued_d = '0;
        end
        if (load) begin
            coef_data_d  = mem[bank_q][rd_addr];
            coef_valid_d = 1'b1;
            coef_last_d  = (issued_q == len_q - 1'b1);
            issued_d     = issued_q + 1'b1;
        end else if (handshake) begin
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
        end
    end

    // Datapath registers; reset clears the stream outputs and error pulses at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q       <= '0;
            len_q        <= '0;
            rev_q        <= 1'b0;
            issued_q     <= '0;
            coef_data_q  <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            wr_err_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            len_q        <= len_d;
            rev_q        <= rev_d;
            issued_q     <= issued_d;
            coef_data_q  <= coef_data_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
            wr_err_q     <= wr_err_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.wr_err     = wr_err_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.coef_data  = coef_data_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.coef_last  = coef_last_q;
endmodule

// File: doc/coef_bank.md
COEF_BANK -- requirements
Module: coef_bank

Interface
REQ-001 Parameter DW, 16, coefficient word width in bits.
REQ-002 Parameter AW, 6, address width; DEPTH = 2**AW words per bank.
REQ-003 Parameter NBANK, 2, number of coefficient banks; BW = max(1, clog2(NBANK)).
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_en  in  1  write strobe for the load port.
REQ-007 wr_bank  in  BW  bank to write.
REQ-008 wr_addr  in  AW  word address to write.
REQ-009 wr_data  in  DW  coefficient to write.
REQ-010 wr_err  out  1  one-cycle pulse when a write is rejected.
REQ-011 start  in  1  launch a stream (sampled only in IDLE).
REQ-012 rd_bank  in  BW  bank to stream, sampled with start.
REQ-013 rd_len  in  AW+1  coefficient count, 1..DEPTH, sampled with start.
REQ-014 rd_rev  in  1  1 = stream addresses rd_len-1 down to 0, sampled with start.
REQ-015 cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-016 busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-017 coef_data  out  DW  streamed coefficient, registered.
REQ-018 coef_valid  out  1  coef_data valid.
REQ-019 coef_ready  in  1  consumer accepts when coef_valid && coef_ready.
REQ-020 coef_last  out  1  high with the final coefficient of a stream.
REQ-021 done  out  1  one-cycle pulse after the final handshake.

Function
REQ-022 Storage: NBANK x DEPTH words of DW bits; synchronous write; contents are not cleared by rst.
REQ-023 A write with wr_en=1 lands at the next edge, except when busy=1 and wr_bank equals the latched stream bank; that write is dropped and wr_err pulses the next cycle.
REQ-024 Writes to any non-streaming bank proceed during a stream with no stall.
REQ-025 FSM states: IDLE, PRIME, STREAM, DONE.
REQ-026 IDLE -> PRIME on start=1 with 1 <= rd_len <= DEPTH and rd_bank < NBANK; bank, len, and rev are latched.
REQ-027 start in IDLE with rd_len=0, rd_len>DEPTH, or rd_bank>=NBANK: start is ignored, state stays IDLE, and cfg_err pulses the next cycle.
REQ-028 start while not IDLE is ignored silently.
REQ-029 Latency: with start accepted at edge t, the first coef_valid is high after edge t+2.
REQ-030 Throughput: with coef_ready held high, one coefficient transfers per cycle with no bubbles.
REQ-031 Backpressure: while coef_valid=1 and coef_ready=0, coef_data, coef_valid, and coef_last hold stable; no coefficient is skipped or duplicated. An internal skid/prefetch register is permitted.
REQ-032 Address order: forward 0,1,...,len-1; reverse len-1,...,0.
REQ-033 coef_last=1 only with the len-th coefficient; for len=1 it is high with the first.
REQ-034 STREAM -> DONE on the final handshake; DONE lasts one cycle with done=1, then IDLE; coef_valid is 0 in DONE.
REQ-035 A write to the streaming bank that coincides with its read cycle is rejected per REQ-023, so streamed data always reflects pre-start contents.
REQ-036 A start in the DONE cycle is ignored; a start is accepted at the earliest in the first cycle back in IDLE.

Reset
REQ-037 rst=1 immediately forces IDLE and drives coef_valid, coef_last, done, busy, wr_err, and cfg_err to 0, with coef_data=0.
REQ-038 rst mid-stream aborts the stream with no done pulse; memory contents are retained; a new start is accepted on the first edge after rst falls.

Verification
REQ-039 Load bank0[0..3] = fff1, ffd1, ffb4, ff9f; start len=4, rev=0, ready=1 at edge t -> data fff1, ffd1, ffb4, ff9f at t+2..t+5; last at t+5; done at t+6.
REQ-040 Same contents, rev=1 -> data ff9f, ffb4, ffd1, fff1; last with fff1.
REQ-041 Stream of 32 words with ready toggling 1,0,0,1,... -> all 32 words arrive exactly once, in order, and stay stable while stalled.
REQ-042 Stream bank0 while writing bank0[2]=1234 and bank1[2]=5678 -> wr_err for the bank0 write only; bank0[2] is unchanged; a read of bank1[2] returns 5678.
REQ-043 start with rd_len=0, then with rd_len=65 (AW=6) -> a cfg_err pulse for each, busy stays 0, no valid.
REQ-044 rst asserted after the 3rd handshake of a len=10 stream -> outputs are 0 at once with no done; a re-run len=10 reproduces the same data from word 0.
